// File: rtl/div_unit.sv
// Multi-cycle unsigned restoring divider: one quotient bit per cycle in CALC,
// with a one-cycle DONE pulse and registered result/flag outputs.
module div_unit #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             done_div,
  output logic             div_by_zero,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH:0]   t;
  logic [WIDTH-1:0] t_sub;
  logic             take;

  always_comb begin
    // R's top bit is always 0 between steps (R < divisor), so only WIDTH bits
    // are stored; T still carries the full WIDTH+1 bits for the compare.
    t     = {r_q, d_q[WIDTH-1]};
    take  = (t >= {1'b0, dvs_q});
    t_sub = t[WIDTH-1:0] - dvs_q;

    state_d = state_q;
    r_d     = r_q;
    d_d     = d_q;
    dvs_d   = dvs_q;
    cnt_d   = cnt_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          d_d   = dividend;
          dvs_d = divisor;
          cnt_d = '0;
          if (divisor == '0) begin
            state_d = DONE;
            quot_d  = '1;
            rem_d   = dividend;
            dbz_d   = 1'b1;
          end else begin
            state_d = CALC;
            r_d     = '0;
          end
        end
      end
      CALC: begin
        r_d   = take ? t_sub : t[WIDTH-1:0];
        // Quotient bits enter D's LSB as dividend bits leave its MSB, so after
        // WIDTH steps D holds the full quotient.
        d_d   = {d_q[WIDTH-2:0], take};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = DONE;
          quot_d  = d_d;
          rem_d   = r_d;
          dbz_d   = 1'b0;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      r_q     <= '0;
      d_q     <= '0;
      dvs_q   <= '0;
      cnt_q   <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      d_q     <= d_d;
      dvs_q   <= dvs_d;
      cnt_q   <= cnt_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;
  assign done_div    = (state_q == DONE);
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_div_unit.sv
// Bench for div_unit (WIDTH=4): latency/result model checked every cycle, plus
// directed vectors with literal expectations.
module tb_div_unit;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic [W-1:0] quotient, remainder;
  logic         done_div, div_by_zero, busy;

  div_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
    .quotient(quotient), .remainder(remainder), .done_div(done_div),
    .div_by_zero(div_by_zero), .busy(busy)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: an accepted request finishes at a fixed cycle; results come from
  // plain / and %, and are published on the DONE cycle and held after.
  int           cyc = 0;
  int           done_at = -10;
  bit           m_busy = 1'b0;
  bit           chk_en = 1'b0;
  logic [W-1:0] pq, pr, eq = '0, er = '0;
  logic         pz, ez = 1'b0;

  always @(posedge clk) begin
    int nc;
    nc = cyc + 1;
    if (!rst) begin
      m_busy = 1'b0;
      eq = '0; er = '0; ez = 1'b0;
    end else if (!m_busy && start) begin
      if (divisor == 0) begin
        pq = '1; pr = dividend; pz = 1'b1; done_at = nc;
      end else begin
        pq = dividend / divisor; pr = dividend % divisor; pz = 1'b0; done_at = nc + W;
      end
      m_busy = 1'b1;
      if (done_at == nc) begin eq = pq; er = pr; ez = pz; end
    end else if (m_busy) begin
      if (nc == done_at) begin eq = pq; er = pr; ez = pz; end
      else if (nc > done_at) m_busy = 1'b0;
    end
    cyc = nc;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model busy", busy, m_busy);
      chk("model done_div", done_div, (m_busy && cyc == done_at));
      chk("model quotient", quotient, eq);
      chk("model remainder", remainder, er);
      chk("model div_by_zero", div_by_zero, ez);
    end
  end

  task automatic go(input int a, input int b);
    start = 1'b1;
    dividend = W'(a);
    divisor = W'(b);
  endtask

  // Called in the cycle the request is presented; drops start next cycle.
  task automatic wait_done(input int lat_e, input int q_e, input int r_e, input int z_e);
    int lat;
    lat = 0;
    @(posedge clk); #1; start = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (done_div === 1'b1) begin lat = k; break; end
      @(posedge clk); #1;
    end
    if (lat == 0) begin
      tests++; fails++;
      $display("FAIL timeout: no done_div within 20 cycles, expected latency %0d", lat_e);
    end else begin
      chk("latency", lat, lat_e);
      chk("quotient", quotient, q_e);
      chk("remainder", remainder, r_e);
      chk("div_by_zero", div_by_zero, z_e);
    end
  endtask

  task automatic run_div(input int a, input int b, input int lat_e, input int q_e,
                         input int r_e, input int z_e);
    @(posedge clk); #1;
    go(a, b);
    wait_done(lat_e, q_e, r_e, z_e);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int pulses, p1, p2;
    repeat (2) @(posedge clk);
    #1; chk_en = 1'b1;
    @(negedge clk);
    chk("reset quotient", quotient, 0);
    chk("reset remainder", remainder, 0);
    chk("reset div_by_zero", div_by_zero, 0);
    chk("reset done_div", done_div, 0);
    chk("reset busy", busy, 0);

    // Request presented in the very first cycle out of reset.
    @(posedge clk); #1;
    rst = 1'b1;
    go(13, 4);
    wait_done(5, 3, 1, 0);

    run_div(7, 0, 1, 15, 7, 1);
    run_div(6, 3, 5, 2, 0, 0);
    run_div(15, 1, 5, 15, 0, 0);
    run_div(3, 9, 5, 0, 3, 0);
    run_div(0, 5, 5, 0, 0, 0);
    run_div(15, 15, 5, 1, 0, 0);

    // start and operands toggled while busy must not disturb 9/2.
    @(posedge clk); #1;
    go(9, 2);
    pulses = 0; p1 = 0;
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk); #1;
      if (c <= 4) go(1, 1); else start = 1'b0;
      @(negedge clk);
      if (done_div === 1'b1) begin
        pulses++; p1 = c;
        chk("busy-imm quotient", quotient, 4);
        chk("busy-imm remainder", remainder, 1);
      end
    end
    chk("busy-imm pulses", pulses, 1);
    chk("busy-imm done cycle", p1, 5);

    // start held through DONE: second acceptance in the IDLE cycle after.
    @(posedge clk); #1;
    go(13, 4);
    pulses = 0; p1 = 0; p2 = 0;
    for (int c = 1; c <= 13; c++) begin
      @(posedge clk); #1;
      if (c == 7) start = 1'b0;
      @(negedge clk);
      if (done_div === 1'b1) begin
        pulses++;
        if (pulses == 1) p1 = c; else p2 = c;
      end
    end
    chk("hold pulses", pulses, 2);
    chk("hold first done", p1, 5);
    chk("hold second done", p2, 11);

    // Reset in cycle 3 of 14/3 aborts it with no done pulse.
    @(posedge clk); #1; go(14, 3);
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1; rst = 1'b0;
    @(posedge clk); #1; rst = 1'b1;
    @(negedge clk);
    chk("abort quotient", quotient, 0);
    chk("abort remainder", remainder, 0);
    chk("abort div_by_zero", div_by_zero, 0);
    chk("abort busy", busy, 0);
    pulses = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (done_div === 1'b1) pulses++;
    end
    chk("abort pulses", pulses, 0);
    run_div(14, 3, 5, 4, 2, 0);

    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        run_div(a, b, (b != 0) ? 5 : 1, (b != 0) ? a / b : 15,
                (b != 0) ? a % b : a, (b == 0) ? 1 : 0);

    @(posedge clk); #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
